// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: shares one memory port between fetch (I) and data (D) requesters, one request outstanding.
// Optional MEMARB_RR_EN selects round-robin priority; otherwise data always wins over fetch.
module mem_arbiter #(
  parameter bit INIT_DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // fetch request / response
  input  logic        i_ireq_valid,
  output logic        o_ireq_ready,
  input  logic [31:0] i_ireq_addr,
  input  logic        i_ireq_wen,
  input  logic [31:0] i_ireq_wdata,
  output logic        o_iresp_valid,
  output logic [31:0] o_iresp_rdata,
  // data-stage request / response
  input  logic        i_dreq_valid,
  output logic        o_dreq_ready,
  input  logic [31:0] i_dreq_addr,
  input  logic        i_dreq_wen,
  input  logic [31:0] i_dreq_wdata,
  output logic        o_dresp_valid,
  output logic [31:0] o_dresp_rdata,
  // downstream memory port
  output logic        o_memreq_valid,
  input  logic        i_memreq_ready,
  output logic [31:0] o_memreq_addr,
  output logic        o_memreq_wen,
  output logic [31:0] o_memreq_wdata,
  input  logic        i_memresp_valid,
  input  logic [31:0] i_memresp_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } state_t;

  state_t r_state;

  logic w_issue_ok;
  logic w_prio_d;
  logic w_sel_d;
  logic w_sel_i;
  logic w_accept;

`ifdef MEMARB_RR_EN
  logic r_prio_d;
  assign w_prio_d = r_prio_d;
`else
  logic w_unused_init;
  assign w_unused_init = INIT_DATA_FIRST;
  assign w_prio_d      = 1'b1;
`endif

  // A response in the same cycle frees the port, allowing back-to-back issue.
  assign w_issue_ok = (r_state == ST_IDLE) | i_memresp_valid;
  assign w_sel_d    = w_issue_ok & i_dreq_valid & (w_prio_d | ~i_ireq_valid);
  assign w_sel_i    = w_issue_ok & ~w_sel_d & i_ireq_valid;
  assign w_accept   = (w_sel_d | w_sel_i) & i_memreq_ready;

  always_comb begin
    o_memreq_valid = 1'b0;
    o_memreq_addr  = 32'd0;
    o_memreq_wen   = 1'b0;
    o_memreq_wdata = 32'd0;
    o_ireq_ready   = 1'b0;
    o_dreq_ready   = 1'b0;
    if (!reset) begin
      if (w_sel_d) begin
        o_memreq_valid = 1'b1;
        o_memreq_addr  = i_dreq_addr;
        o_memreq_wen   = i_dreq_wen;
        o_memreq_wdata = i_dreq_wdata;
        o_dreq_ready   = i_memreq_ready;
      end else if (w_sel_i) begin
        o_memreq_valid = 1'b1;
        o_memreq_addr  = i_ireq_addr;
        o_memreq_wen   = i_ireq_wen;
        o_memreq_wdata = i_ireq_wdata;
        o_ireq_ready   = i_memreq_ready;
      end
    end
  end

  // A response seen in IDLE matches neither WAIT state and is silently dropped.
  always_comb begin
    o_iresp_valid = 1'b0;
    o_dresp_valid = 1'b0;
    o_iresp_rdata = 32'd0;
    o_dresp_rdata = 32'd0;
    if (!reset) begin
      o_iresp_valid = i_memresp_valid & (r_state == ST_WAIT_I);
      o_dresp_valid = i_memresp_valid & (r_state == ST_WAIT_D);
      o_iresp_rdata = i_memresp_rdata;
      o_dresp_rdata = i_memresp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
`ifdef MEMARB_RR_EN
      r_prio_d <= INIT_DATA_FIRST;
`endif
    end else begin
      if (w_accept) begin
        r_state <= w_sel_d ? ST_WAIT_D : ST_WAIT_I;
      end else if (i_memresp_valid) begin
        r_state <= ST_IDLE;
      end
`ifdef MEMARB_RR_EN
      // Priority passes to whichever side was not just granted.
      if (w_accept) begin
        r_prio_d <= ~w_sel_d;
      end
`endif
    end
  end

endmodule
`default_nettype wire
